// File: rtl/pc_gen.sv
// Fetch program-counter generator: sequential/redirect/trap target selection,
// a held fetch request handshake, and a misalignment halt.
module pc_gen #(
    parameter int              XLEN      = 64,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(64'h8000_0000),
    parameter int              IALIGN    = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_pc,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [XLEN-1:0] req_pc,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_prev,
    output logic            misaligned,
    output logic [XLEN-1:0] misaligned_addr
);

    localparam int AB = (IALIGN == 2) ? 1 : 2;

    typedef enum logic [1:0] {IDLE, ISSUE, HALT} state_t;

    state_t          state, state_nxt;
    logic            held, held_nxt;
    logic            pend_valid, pend_valid_nxt;
    logic            pend_is_trap, pend_is_trap_nxt;
    logic [XLEN-1:0] pend_pc, pend_pc_nxt;
    logic [XLEN-1:0] pc_out_nxt, pc_prev_nxt, misaligned_addr_nxt;
    logic            misaligned_nxt;
    logic [XLEN-1:0] tgt;
    logic            tgt_trap;
    logic            fire;

    function automatic logic [XLEN-1:0] align_trap(input logic [XLEN-1:0] a);
        return {a[XLEN-1:AB], {AB{1'b0}}};
    endfunction

    function automatic logic is_misaligned(input logic [XLEN-1:0] a);
        return |a[AB-1:0];
    endfunction

    assign req_valid = (state == ISSUE) && (!stall || held);
    assign fire      = req_valid && req_ready;
    assign req_pc    = pc_out;

    always_comb begin
        tgt      = pc_out + XLEN'(IALIGN);
        tgt_trap = 1'b0;
        if (trap_valid) begin
            tgt      = align_trap(trap_pc);
            tgt_trap = 1'b1;
        end else if (redirect_valid) begin
            tgt = redirect_pc;
        end else if (pend_valid) begin
            tgt      = pend_pc;
            tgt_trap = pend_is_trap;
        end
    end

    always_comb begin
        state_nxt           = state;
        held_nxt            = held;
        pend_valid_nxt      = pend_valid;
        pend_is_trap_nxt    = pend_is_trap;
        pend_pc_nxt         = pend_pc;
        pc_out_nxt          = pc_out;
        pc_prev_nxt         = pc_prev;
        misaligned_nxt      = 1'b0;
        misaligned_addr_nxt = misaligned_addr;
        case (state)
            IDLE: state_nxt = ISSUE;
            ISSUE: begin
                if (fire || (!req_valid && (trap_valid || redirect_valid))) begin
                    held_nxt       = 1'b0;
                    pend_valid_nxt = 1'b0;
                    if (!tgt_trap && is_misaligned(tgt)) begin
                        misaligned_nxt      = 1'b1;
                        misaligned_addr_nxt = tgt;
                        state_nxt           = HALT;
                    end else begin
                        pc_out_nxt  = tgt;
                        pc_prev_nxt = pc_out;
                    end
                end else if (req_valid) begin
                    // Request stays up; remember where to go once it is accepted.
                    held_nxt = 1'b1;
                    if (trap_valid) begin
                        pend_valid_nxt   = 1'b1;
                        pend_is_trap_nxt = 1'b1;
                        pend_pc_nxt      = align_trap(trap_pc);
                    end else if (redirect_valid && !(pend_valid && pend_is_trap)) begin
                        pend_valid_nxt   = 1'b1;
                        pend_is_trap_nxt = 1'b0;
                        pend_pc_nxt      = redirect_pc;
                    end
                end
            end
            HALT: begin
                held_nxt       = 1'b0;
                pend_valid_nxt = 1'b0;
                if (trap_valid) begin
                    pc_out_nxt  = align_trap(trap_pc);
                    pc_prev_nxt = pc_out;
                    state_nxt   = ISSUE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            held            <= 1'b0;
            pend_valid      <= 1'b0;
            pend_is_trap    <= 1'b0;
            pend_pc         <= '0;
            pc_out          <= RESET_VEC;
            pc_prev         <= '0;
            misaligned      <= 1'b0;
            misaligned_addr <= '0;
        end else begin
            state           <= state_nxt;
            held            <= held_nxt;
            pend_valid      <= pend_valid_nxt;
            pend_is_trap    <= pend_is_trap_nxt;
            pend_pc         <= pend_pc_nxt;
            pc_out          <= pc_out_nxt;
            pc_prev         <= pc_prev_nxt;
            misaligned      <= misaligned_nxt;
            misaligned_addr <= misaligned_addr_nxt;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: expected fetch PCs are queued by the stimulus,
// monitors pop them on every accepted request.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst_n, stall, redirect_valid, trap_valid, req_ready;
    logic [63:0] redirect_pc, trap_pc;
    logic        req_valid, misaligned;
    logic [63:0] req_pc, pc_out, pc_prev, misaligned_addr;

    logic        rst32_n, stall32, rv32, tv32, ready32;
    logic [31:0] rp32, tp32;
    logic        req_valid32, mis32;
    logic [31:0] req_pc32, pc_out32, pc_prev32, mis_addr32;

    int checks = 0;
    int errors = 0;
    logic [63:0] q64[$];
    logic [31:0] q32[$];

    always #5 clk = ~clk;

    pc_gen #(.XLEN(64), .RESET_VEC(64'h8000_0000), .IALIGN(4)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .trap_valid(trap_valid), .trap_pc(trap_pc),
        .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc),
        .pc_out(pc_out), .pc_prev(pc_prev),
        .misaligned(misaligned), .misaligned_addr(misaligned_addr)
    );

    pc_gen #(.XLEN(32), .RESET_VEC(32'hFFFF_FFFC), .IALIGN(4)) dut32 (
        .clk(clk), .rst_n(rst32_n), .stall(stall32),
        .redirect_valid(rv32), .redirect_pc(rp32),
        .trap_valid(tv32), .trap_pc(tp32),
        .req_valid(req_valid32), .req_ready(ready32), .req_pc(req_pc32),
        .pc_out(pc_out32), .pc_prev(pc_prev32),
        .misaligned(mis32), .misaligned_addr(mis_addr32)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitors: every accepted request must match the next queued PC.
    always @(negedge clk) begin
        if (req_valid && req_ready) begin
            checks++;
            if (q64.size() == 0) begin
                errors++;
                $display("FAIL fire64_unexpected actual=%h required=none", req_pc);
            end else begin
                logic [63:0] e;
                e = q64.pop_front();
                if (req_pc !== e) begin
                    errors++;
                    $display("FAIL fire64 actual=%h required=%h", req_pc, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (req_valid32 && ready32) begin
            checks++;
            if (q32.size() == 0) begin
                errors++;
                $display("FAIL fire32_unexpected actual=%h required=none", req_pc32);
            end else begin
                logic [31:0] e;
                e = q32.pop_front();
                if (req_pc32 !== e) begin
                    errors++;
                    $display("FAIL fire32 actual=%h required=%h", req_pc32, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; stall = 0; redirect_valid = 0; trap_valid = 0; req_ready = 1;
        redirect_pc = '0; trap_pc = '0;
        rst32_n = 0; stall32 = 0; rv32 = 0; tv32 = 0; ready32 = 0; rp32 = '0; tp32 = '0;
        step(); step();
        chk("rst_pc_out", pc_out, 64'h8000_0000);
        chk("rst_pc_prev", pc_prev, 64'h0);
        chk("rst_req_valid", {63'h0, req_valid}, 64'h0);
        chk("rst_misaligned", {63'h0, misaligned}, 64'h0);
        chk("rst_mis_addr", misaligned_addr, 64'h0);

        rst_n = 1;
        step();
        chk("first_req_valid", {63'h0, req_valid}, 64'h1);
        chk("first_req_pc", req_pc, 64'h8000_0000);
        q64.push_back(64'h8000_0000); q64.push_back(64'h8000_0004);
        q64.push_back(64'h8000_0008); q64.push_back(64'h8000_000C);
        step();
        chk("seq_pc1", pc_out, 64'h8000_0004);
        chk("seq_prev1", pc_prev, 64'h8000_0000);
        step();
        chk("seq_pc2", pc_out, 64'h8000_0008);
        chk("seq_prev2", pc_prev, 64'h8000_0004);
        step();
        step();
        chk("hold_start_pc", pc_out, 64'h8000_0010);
        req_ready = 0; redirect_valid = 1; redirect_pc = 64'h8000_0100;
        step();
        redirect_valid = 0; stall = 1;
        chk("hold_valid1", {63'h0, req_valid}, 64'h1);
        chk("hold_pc1", req_pc, 64'h8000_0010);
        step();
        chk("hold_valid2", {63'h0, req_valid}, 64'h1);
        chk("hold_pc2", req_pc, 64'h8000_0010);
        req_ready = 1; stall = 0;
        q64.push_back(64'h8000_0010);
        step();
        req_ready = 0;
        chk("redir_after_fire", req_pc, 64'h8000_0100);
        redirect_valid = 1; redirect_pc = 64'h200;
        step();
        redirect_valid = 0; trap_valid = 1; trap_pc = 64'h300;
        step();
        trap_valid = 0; redirect_valid = 1; redirect_pc = 64'h400;
        step();
        redirect_valid = 0;
        chk("pend_hold_pc", req_pc, 64'h8000_0100);
        req_ready = 1;
        q64.push_back(64'h8000_0100);
        step();
        chk("trap_wins_pc", pc_out, 64'h300);
        chk("trap_wins_prev", pc_prev, 64'h8000_0100);
        redirect_valid = 1; redirect_pc = 64'h8000_0102;
        q64.push_back(64'h300);
        step();
        chk("mis_pulse", {63'h0, misaligned}, 64'h1);
        chk("mis_addr", misaligned_addr, 64'h8000_0102);
        chk("mis_req_valid", {63'h0, req_valid}, 64'h0);
        chk("mis_pc_kept", pc_out, 64'h300);
        redirect_pc = 64'h700;
        step();
        chk("mis_pulse_end", {63'h0, misaligned}, 64'h0);
        chk("halt_req_valid", {63'h0, req_valid}, 64'h0);
        chk("halt_ignores_redir", pc_out, 64'h300);
        redirect_valid = 0; trap_valid = 1; trap_pc = 64'h8000_0403;
        step();
        trap_valid = 0;
        chk("halt_trap_pc", pc_out, 64'h8000_0400);
        chk("resume_valid", {63'h0, req_valid}, 64'h1);
        q64.push_back(64'h8000_0400);
        step();
        stall = 1;
        #1;
        chk("stall_no_req", {63'h0, req_valid}, 64'h0);
        redirect_valid = 1; redirect_pc = 64'h500;
        step();
        redirect_valid = 0;
        chk("stall_redir_pc", pc_out, 64'h500);
        chk("stall_redir_prev", pc_prev, 64'h8000_0404);
        chk("stall_redir_valid", {63'h0, req_valid}, 64'h0);
        step();
        chk("stall_still_low", {63'h0, req_valid}, 64'h0);
        stall = 0; req_ready = 0;
        #1;
        chk("unstall_valid", {63'h0, req_valid}, 64'h1);
        chk("unstall_pc", req_pc, 64'h500);
        redirect_valid = 1; redirect_pc = 64'h900;
        step();
        redirect_valid = 0;
        rst_n = 0;
        #1;
        chk("midrst_valid", {63'h0, req_valid}, 64'h0);
        chk("midrst_pc", pc_out, 64'h8000_0000);
        chk("midrst_prev", pc_prev, 64'h0);
        step();
        rst_n = 1;
        step(); step();
        chk("postrst_pc", req_pc, 64'h8000_0000);
        req_ready = 1;
        q64.push_back(64'h8000_0000);
        step();
        req_ready = 0;
        chk("postrst_no_pending", pc_out, 64'h8000_0004);

        rst32_n = 1;
        step();
        chk("w32_first_pc", {32'h0, req_pc32}, 64'hFFFF_FFFC);
        ready32 = 1;
        q32.push_back(32'hFFFF_FFFC);
        step();
        chk("w32_wrap_pc", {32'h0, pc_out32}, 64'h0);
        chk("w32_wrap_prev", {32'h0, pc_prev32}, 64'hFFFF_FFFC);
        tv32 = 1; tp32 = 32'h1000; rv32 = 1; rp32 = 32'h2000;
        q32.push_back(32'h0);
        step();
        tv32 = 0; rv32 = 0; ready32 = 0;
        chk("w32_trap_over_redir", {32'h0, pc_out32}, 64'h1000);
        step();

        chk("q64_drained", 64'(q64.size()), 64'h0);
        chk("q32_drained", 64'(q32.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning address width.
REQ-002 SHALL have parameter RESET_VEC, default 64'h8000_0000, meaning the first fetch address after reset.
REQ-003 SHALL have parameter IALIGN, default 4, legal values 2 or 4, meaning sequential increment and required alignment in bytes.
REQ-004 SHALL have these ports: clk, input, 1, clock; all state updates on rising edge.
REQ-005 SHALL have these ports: rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have these ports: stall, input, 1, suppresses issuing a new fetch request.
REQ-007 SHALL have these ports: redirect_valid, input, 1; and redirect_pc, input, XLEN; together a branch/jump target.
REQ-008 SHALL have these ports: trap_valid, input, 1; and trap_pc, input, XLEN; together a trap/return vector.
REQ-009 SHALL have these ports: req_valid, output, 1; req_ready, input, 1; req_pc, output, XLEN; together the fetch request handshake.
REQ-010 SHALL have these ports: pc_out, output, XLEN, current fetch PC; pc_prev, output, XLEN, PC before the last update.
REQ-011 SHALL have these ports: misaligned, output, 1, one-cycle pulse; misaligned_addr, output, XLEN, the offending target.

Function
REQ-012 SHALL implement states IDLE, ISSUE and HALT; IDLE moves to ISSUE unconditionally on the next edge.
REQ-013 SHALL drive req_pc = pc_out at all times.
REQ-014 SHALL assert req_valid only in ISSUE, when stall=0 or a request is held (raised earlier and not yet accepted).
REQ-015 SHALL keep a raised request stable until accepted: req_valid stays 1 and req_pc is unchanged until req_valid&req_ready (fire), regardless of stall, redirect or trap.
REQ-016 SHALL select the next target with priority trap_pc (trap_valid) > redirect_pc (redirect_valid) > pending target > pc_out+IALIGN.
- Addition wraps modulo 2^XLEN.
REQ-017 SHALL, on fire, load pc_out with the selected target, load pc_prev with the old pc_out, and clear pending.
REQ-018 SHALL, when a request is held (not fired) and trap_valid or redirect_valid is high, capture that target into a pending register with a pending_is_trap flag.
- A later redirect overwrites a pending redirect.
- A redirect never overwrites a pending trap.
- A trap overwrites anything.
REQ-019 SHALL, in ISSUE with no request held (stalled), apply trap_valid or redirect_valid immediately: pc_out loads the target and pc_prev loads the old pc_out.
REQ-020 SHALL check a loaded redirect/pending/sequential target for misalignment (target mod IALIGN != 0).
- On misalignment: pc_out is not updated, misaligned pulses 1 for one cycle, misaligned_addr captures the target, and the state goes to HALT.
REQ-021 SHALL treat misaligned trap_pc by forcing its low log2(IALIGN) bits to 0; a trap is never flagged misaligned.
REQ-022 SHALL hold req_valid=0 in HALT, ignore redirect_valid there, and leave HALT only on trap_valid: pc_out loads the aligned trap_pc and the state goes to ISSUE.
REQ-023 SHALL give trap priority when trap_valid and redirect_valid are high in the same cycle; the redirect is dropped.

Reset
REQ-024 SHALL, while rst_n=0, force pc_out=RESET_VEC, pc_prev=0, state IDLE, req_valid=0, misaligned=0, misaligned_addr=0, and pending cleared.
REQ-025 SHALL abandon an in-flight request on reset asserted mid-operation: req_valid drops asynchronously and no pending target survives.
REQ-026 SHALL raise the first request (req_pc=RESET_VEC) in the second cycle after rst_n deasserts, provided stall=0.

Verification
REQ-027 SHALL cover: reset release, req_ready=1, stall=0 -> req_pc sequence 0x8000_0000, 0x8000_0004, 0x8000_0008 on consecutive cycles; pc_prev lags by one.
REQ-028 SHALL cover: request at 0x8000_0010 held (req_ready=0) for 3 cycles, redirect to 0x8000_0100 in cycle 1 -> req_pc stays 0x8000_0010 until fire, then 0x8000_0100.
REQ-029 SHALL cover: while held, redirect 0x200 then trap 0x300 then redirect 0x400 -> after fire pc_out=0x300.
REQ-030 SHALL cover: IALIGN=4, redirect to 0x8000_0102 -> misaligned pulse, misaligned_addr=0x8000_0102, req_valid=0; later trap_pc 0x8000_0403 -> pc_out=0x8000_0400, requests resume.
REQ-031 SHALL cover: stall=1 with no request held and redirect 0x500 -> pc_out=0x500 next cycle, req_valid=0 until stall drops.
REQ-032 SHALL cover: XLEN=32, pc_out=0xFFFF_FFFC, fire -> pc_out=0x0000_0000; also rst_n pulse mid-hold -> req_valid=0 immediately, pc_out=RESET_VEC.
